// File: rtl/mouse_select_ctrl_pkg.sv
// Shared constants and helpers for the mouse selection controller:
// state encoding, coordinate width and parameter defaults.
package mouse_select_ctrl_pkg;

  localparam int COORD_W         = 10;
  localparam int DBL_WINDOW_DEF  = 25_000_000;
  localparam int DRAG_THRESH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_DRAG  = 2'd2,
    ST_WAIT2 = 2'd3
  } state_e;

  // Distance between two coordinates, one bit wider so 0 - n cannot wrap.
  function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b);
    logic [COORD_W:0] a_ext;
    logic [COORD_W:0] b_ext;
    a_ext = {1'b0, a};
    b_ext = {1'b0, b};
    if (a_ext >= b_ext) begin
      abs_diff = a_ext - b_ext;
    end else begin
      abs_diff = b_ext - a_ext;
    end
  endfunction

  // Smaller / larger of two coordinates, used to normalise the rectangle.
  function automatic logic [COORD_W-1:0] coord_min(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
    coord_min = (a < b) ? a : b;
  endfunction

  function automatic logic [COORD_W-1:0] coord_max(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
    coord_max = (a < b) ? b : a;
  endfunction

endpackage

// File: rtl/click_timer.sv
// Double-click window counter: clears on request, counts while enabled,
// sticks at LIMIT and flags expiry once it gets there.
module click_timer #(
  parameter int LIMIT = 20,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear has priority, otherwise count up but never past LIMIT.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIMIT_C)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT_C);

endmodule

// File: rtl/mouse_select_ctrl.sv
// Mouse selection controller: turns raw button levels and cursor position
// into click / double-click pulses and a normalised drag rectangle.
module mouse_select_ctrl
  import mouse_select_ctrl_pkg::*;
#(
  parameter int DBL_WINDOW  = DBL_WINDOW_DEF,
  parameter int DRAG_THRESH = DRAG_THRESH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [9:0]   mouse_x,
  input  logic [9:0]   mouse_y,
  input  logic         mouse_left,
  input  logic         mouse_right,
  output logic         click,
  output logic         dbl_click,
  output logic         sel_active,
  output logic         sel_valid,
  output logic [9:0]   sel_x0,
  output logic [9:0]   sel_y0,
  output logic [9:0]   sel_x1,
  output logic [9:0]   sel_y1,
  output logic [1:0]   state
);

  localparam logic [COORD_W:0] THRESH_C = (COORD_W + 1)'(DRAG_THRESH);

  state_e             state_q, state_d;
  logic               left_prev_q, left_prev_d;
  logic               right_prev_q, right_prev_d;
  logic [COORD_W-1:0] anchor_x_q, anchor_x_d;
  logic [COORD_W-1:0] anchor_y_q, anchor_y_d;
  logic [COORD_W-1:0] end_x_q, end_x_d;
  logic [COORD_W-1:0] end_y_q, end_y_d;
  logic               dbl_q, dbl_d;
  logic               sel_active_q, sel_active_d;
  logic               sel_valid_q, sel_valid_d;
  logic               click_q, click_d;
  logic               dbl_click_q, dbl_click_d;

  logic               left_rise;
  logic               right_rise;
  logic               over_thresh;
  logic               timer_clear;
  logic               timer_enable;
  logic               timer_expired;

  click_timer #(
    .LIMIT (DBL_WINDOW)
  ) u_click_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // Button edge detection; a left press is ignored while right is held.
  always_comb begin
    left_prev_d  = mouse_left;
    right_prev_d = mouse_right;
    right_rise   = mouse_right & ~right_prev_q;
    left_rise    = mouse_left & ~left_prev_q & ~mouse_right;
    over_thresh  = (abs_diff(mouse_x, anchor_x_q) > THRESH_C) ||
                   (abs_diff(mouse_y, anchor_y_q) > THRESH_C);
  end

  // Next-state and registered-output logic for the selection FSM.
  always_comb begin
    state_d      = state_q;
    anchor_x_d   = anchor_x_q;
    anchor_y_d   = anchor_y_q;
    end_x_d      = end_x_q;
    end_y_d      = end_y_q;
    dbl_d        = dbl_q;
    sel_active_d = sel_active_q;
    sel_valid_d  = sel_valid_q;
    click_d      = 1'b0;
    dbl_click_d  = 1'b0;
    timer_clear  = 1'b0;
    timer_enable = (state_q == ST_WAIT2);

    if (right_rise) begin
      // Right button cancels everything, whatever the left button does.
      state_d      = ST_IDLE;
      sel_active_d = 1'b0;
      sel_valid_d  = 1'b0;
      dbl_d        = 1'b0;
      timer_clear  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (left_rise) begin
            anchor_x_d = mouse_x;
            anchor_y_d = mouse_y;
            state_d    = ST_PRESS;
          end
        end
        ST_PRESS: begin
          // Release is checked first so a move on the release cycle is ignored.
          if (!mouse_left) begin
            if (dbl_q) begin
              state_d = ST_IDLE;
            end else begin
              click_d     = 1'b1;
              timer_clear = 1'b1;
              state_d     = ST_WAIT2;
            end
          end else if (over_thresh) begin
            state_d      = ST_DRAG;
            sel_active_d = 1'b1;
            sel_valid_d  = 1'b0;
            end_x_d      = mouse_x;
            end_y_d      = mouse_y;
          end
        end
        ST_DRAG: begin
          end_x_d = mouse_x;
          end_y_d = mouse_y;
          if (!mouse_left) begin
            sel_active_d = 1'b0;
            sel_valid_d  = 1'b1;
            state_d      = ST_IDLE;
          end
        end
        ST_WAIT2: begin
          if (timer_expired) begin
            // Window closed: a press now is an ordinary first press.
            if (left_rise) begin
              anchor_x_d = mouse_x;
              anchor_y_d = mouse_y;
              dbl_d      = 1'b0;
              state_d    = ST_PRESS;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (left_rise) begin
            dbl_click_d = 1'b1;
            anchor_x_d  = mouse_x;
            anchor_y_d  = mouse_y;
            dbl_d       = 1'b1;
            state_d     = ST_PRESS;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (state_d == ST_IDLE) begin
      dbl_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      left_prev_q  <= 1'b0;
      right_prev_q <= 1'b0;
      anchor_x_q   <= '0;
      anchor_y_q   <= '0;
      end_x_q      <= '0;
      end_y_q      <= '0;
      dbl_q        <= 1'b0;
      sel_active_q <= 1'b0;
      sel_valid_q  <= 1'b0;
      click_q      <= 1'b0;
      dbl_click_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      left_prev_q  <= left_prev_d;
      right_prev_q <= right_prev_d;
      anchor_x_q   <= anchor_x_d;
      anchor_y_q   <= anchor_y_d;
      end_x_q      <= end_x_d;
      end_y_q      <= end_y_d;
      dbl_q        <= dbl_d;
      sel_active_q <= sel_active_d;
      sel_valid_q  <= sel_valid_d;
      click_q      <= click_d;
      dbl_click_q  <= dbl_click_d;
    end
  end

  // Outputs decoded from registers, forced quiet while reset is held.
  always_comb begin
    click      = click_q & rst;
    dbl_click  = dbl_click_q & rst;
    sel_active = sel_active_q & rst;
    sel_valid  = sel_valid_q & rst;
    sel_x0     = rst ? coord_min(anchor_x_q, end_x_q) : '0;
    sel_x1     = rst ? coord_max(anchor_x_q, end_x_q) : '0;
    sel_y0     = rst ? coord_min(anchor_y_q, end_y_q) : '0;
    sel_y1     = rst ? coord_max(anchor_y_q, end_y_q) : '0;
    state      = state_q;
  end

endmodule
